// File: rtl/branch_predict_gshare_ckpt.sv
// Global-history / gshare direction predictor with per-branch GHR checkpoints.
// PHT swept to CTR_INIT after reset; speculative GHR restored on M-stage mispredict.
module branch_predict_gshare_ckpt #(
  parameter int         PC_W      = 32,
  parameter int         GHR_W     = 8,
  parameter int         PHT_IDX_W = 10,
  parameter int         MODE      = 1,
  parameter logic [1:0] CTR_INIT  = 2'b10,
  parameter int         CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  pcF,
  input  logic             branchF,
  input  logic             stallF,
  input  logic             flushD,
  input  logic             stallD,
  output logic             pred_takeD,
  input  logic             branchD,
  output logic [GHR_W-1:0] ghrD,
  input  logic             branchM,
  input  logic [PC_W-1:0]  pcM,
  input  logic [GHR_W-1:0] ghrM,
  input  logic             pred_takeM,
  input  logic             actual_takeM,
  output logic             init_done,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int                   PHT_N    = 1 << PHT_IDX_W;
  localparam logic [PHT_IDX_W-1:0] PTR_ONE  = PHT_IDX_W'(1);
  localparam logic [PHT_IDX_W-1:0] PTR_LAST = PHT_IDX_W'(PHT_N - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t               state_q, state_d;
  logic [PHT_IDX_W-1:0] ptr_q, ptr_d;
  logic [GHR_W-1:0]     ghr_q, ghr_d;
  logic                 dpred_q, dpred_d;
  logic [GHR_W-1:0]     dghr_q, dghr_d;
  logic [CNT_W-1:0]     branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]     mispred_cnt_q, mispred_cnt_d;

  logic [1:0]           pht_q [PHT_N];
  logic                 pht_we;
  logic [PHT_IDX_W-1:0] pht_widx;
  logic [1:0]           pht_wdat;

  logic                 run;
  logic [PHT_IDX_W-1:0] idx_f, idx_m;
  logic                 pred_f;
  logic [1:0]           ctr_m, ctr_m_upd;
  logic [GHR_W-1:0]     ghr_shift_f, ghr_repair;
  logic                 unused_pc;

  function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [PC_W-1:0]  pc,
                                                     input logic [GHR_W-1:0] ghr);
    logic [PHT_IDX_W-1:0] h;
    h = '0;
    h[GHR_W-1:0] = ghr;
    if (MODE == 1) return pc[PHT_IDX_W+1:2] ^ h;
    return h;
  endfunction

  // Only the index slice of each PC matters; the rest is deliberately ignored.
  assign unused_pc = ^{pcF, pcM};

  assign run    = (state_q == S_RUN);
  assign idx_f  = pht_index(pcF, ghr_q);
  assign idx_m  = pht_index(pcM, ghrM);
  assign pred_f = run & pht_q[idx_f][1];
  assign ctr_m  = pht_q[idx_m];

  always_comb begin
    ctr_m_upd = ctr_m;
    if (actual_takeM && ctr_m != 2'b11) ctr_m_upd = ctr_m + 2'b01;
    else if (!actual_takeM && ctr_m != 2'b00) ctr_m_upd = ctr_m - 2'b01;
  end

  if (GHR_W == 1) begin : g_ghr_one
    assign ghr_shift_f = pred_f;
    assign ghr_repair  = actual_takeM;
  end else begin : g_ghr_multi
    assign ghr_shift_f = {ghr_q[GHR_W-2:0], pred_f};
    assign ghr_repair  = {ghrM[GHR_W-2:0], actual_takeM};
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    ghr_d         = ghr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    pht_we        = 1'b0;
    pht_widx      = ptr_q;
    pht_wdat      = CTR_INIT;
    if (state_q == S_INIT) begin
      pht_we = 1'b1;
      ptr_d  = ptr_q + PTR_ONE;
      ghr_d  = '0;
      if (ptr_q == PTR_LAST) state_d = S_RUN;
    end else begin
      if (branchF && !stallF) ghr_d = ghr_shift_f;
      if (branchM) begin
        pht_we   = 1'b1;
        pht_widx = idx_m;
        pht_wdat = ctr_m_upd;
        if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_ONE;
        // The F branch in the same cycle is younger and gets flushed, so repair wins.
        if (pred_takeM != actual_takeM) begin
          ghr_d = ghr_repair;
          if (mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + CNT_ONE;
        end
      end
    end
  end

  always_comb begin
    dpred_d = dpred_q;
    dghr_d  = dghr_q;
    if (flushD) begin
      dpred_d = 1'b0;
      dghr_d  = '0;
    end else if (!stallD) begin
      dpred_d = pred_f;
      dghr_d  = ghr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_INIT;
      ptr_q         <= '0;
      ghr_q         <= '0;
      dpred_q       <= 1'b0;
      dghr_q        <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      ghr_q         <= ghr_d;
      dpred_q       <= dpred_d;
      dghr_q        <= dghr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // No reset on the table itself: the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (pht_we && !rst) pht_q[pht_widx] <= pht_wdat;
  end

  assign pred_takeD  = branchD & dpred_q;
  assign ghrD        = dghr_q;
  assign init_done   = run;
  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predict_gshare_ckpt.sv
// Directed bench: gshare instance exercised end to end, a global-index instance
// checked for PC-independence.
module tb_branch_predict_gshare_ckpt;
  localparam int PC_W = 32;
  localparam int GHR_W = 4;
  localparam int IDX_W = 4;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [PC_W-1:0]  pcF, pcM;
  logic             branchF, stallF, flushD, stallD, branchD, branchM, pred_takeM, actual_takeM;
  logic [GHR_W-1:0] ghrM;
  logic             pred_takeD, init_done;
  logic [GHR_W-1:0] ghrD;
  logic [CNT_W-1:0] branch_cnt, mispred_cnt;

  logic [PC_W-1:0]  g_pcF, g_pcM;
  logic             g_branchF, g_branchD, g_branchM, g_pred_takeM, g_actual_takeM;
  logic [GHR_W-1:0] g_ghrM;
  logic             g_pred_takeD, g_init_done;
  logic [GHR_W-1:0] g_ghrD;
  logic [CNT_W-1:0] g_branch_cnt, g_mispred_cnt;

  int vectors;
  int miscompares;

  branch_predict_gshare_ckpt #(
    .PC_W(PC_W), .GHR_W(GHR_W), .PHT_IDX_W(IDX_W), .MODE(1), .CTR_INIT(2'b10), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst), .pcF(pcF), .branchF(branchF), .stallF(stallF),
    .flushD(flushD), .stallD(stallD), .pred_takeD(pred_takeD), .branchD(branchD),
    .ghrD(ghrD), .branchM(branchM), .pcM(pcM), .ghrM(ghrM), .pred_takeM(pred_takeM),
    .actual_takeM(actual_takeM), .init_done(init_done), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  branch_predict_gshare_ckpt #(
    .PC_W(PC_W), .GHR_W(GHR_W), .PHT_IDX_W(IDX_W), .MODE(0), .CTR_INIT(2'b10), .CNT_W(CNT_W)
  ) u_glob (
    .clk(clk), .rst(rst), .pcF(g_pcF), .branchF(g_branchF), .stallF(1'b0),
    .flushD(1'b0), .stallD(1'b0), .pred_takeD(g_pred_takeD), .branchD(g_branchD),
    .ghrD(g_ghrD), .branchM(g_branchM), .pcM(g_pcM), .ghrM(g_ghrM), .pred_takeM(g_pred_takeM),
    .actual_takeM(g_actual_takeM), .init_done(g_init_done), .branch_cnt(g_branch_cnt),
    .mispred_cnt(g_mispred_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_idle();
    branchM = 1'b0; pred_takeM = 1'b0; actual_takeM = 1'b0; ghrM = '0; pcM = '0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1;
    pcF = '0; branchF = 1'b0; stallF = 1'b0; flushD = 1'b0; stallD = 1'b0; branchD = 1'b0;
    m_idle();
    g_pcF = '0; g_pcM = '0; g_branchF = 1'b0; g_branchD = 1'b0; g_branchM = 1'b0;
    g_pred_takeM = 1'b0; g_actual_takeM = 1'b0; g_ghrM = '0;
    tick();
    rst = 1'b0;
    chk("rst_branch_cnt", branch_cnt, 0);
    chk("rst_mispred_cnt", mispred_cnt, 0);

    // Sweep with fetch and M traffic that must all be ignored.
    pcF = 32'h4; branchF = 1'b1; branchD = 1'b1;
    branchM = 1'b1; pred_takeM = 1'b1; actual_takeM = 1'b0; ghrM = 4'hf; pcM = 32'h8;
    for (int i = 0; i < 16; i++) begin
      chk("init_done_low", init_done, 0);
      chk("init_predD", pred_takeD, 0);
      chk("init_ghrD", ghrD, 0);
      tick();
    end
    branchF = 1'b0; m_idle();
    chk("init_done_high", init_done, 1);
    chk("glob_init_done", g_init_done, 1);
    chk("init_branch_cnt", branch_cnt, 0);
    chk("init_mispred_cnt", mispred_cnt, 0);
    chk("init_ghr_held", ghrD, 0);

    for (int i = 0; i < 16; i++) begin
      pcF = 32'(i * 4);
      tick();
      chk("post_init_taken", pred_takeD, 1);
    end
    flushD = 1'b1;
    tick();
    chk("flush_pred", pred_takeD, 0);
    flushD = 1'b0;

    // Global-index instance: PC must not affect the index.
    g_branchD = 1'b1; g_pcF = 32'h14;
    tick();
    chk("glob_pred_init", g_pred_takeD, 1);
    g_branchM = 1'b1; g_pcM = 32'h3c; g_ghrM = '0;
    tick(); tick();
    g_branchM = 1'b0;
    tick();
    chk("glob_pc_ignored", g_pred_takeD, 0);
    chk("glob_branch_cnt", g_branch_cnt, 2);

    // Saturation on idx0 (pcM=0, ghrM=0): 10->01->00->00.
    branchM = 1'b1; pcM = '0; ghrM = '0;
    tick(); tick(); tick();
    branchM = 1'b0; pcF = 32'h0;
    tick();
    chk("sat_low_pred", pred_takeD, 0);
    pcF = 32'h4;
    tick();
    chk("other_idx_pred", pred_takeD, 1);
    // Taken updates while F reads the same entry: read sees the pre-write value.
    pcF = 32'h0; branchM = 1'b1; pred_takeM = 1'b1; actual_takeM = 1'b1;
    tick();
    chk("taken1_old00", pred_takeD, 0);
    tick();
    chk("taken2_old01", pred_takeD, 0);
    tick();
    chk("taken3_old10", pred_takeD, 1);
    m_idle();
    tick();
    chk("sat_high_pred", pred_takeD, 1);
    chk("sat_branch_cnt", branch_cnt, 6);
    chk("sat_mispred_cnt", mispred_cnt, 0);

    // Speculative shifts: all predicted taken.
    pcF = 32'h4; branchF = 1'b1;
    tick();
    chk("ckpt0", ghrD, 4'b0000);
    chk("ckpt0_pred", pred_takeD, 1);
    tick();
    chk("ckpt1", ghrD, 4'b0001);
    tick();
    chk("ckpt2", ghrD, 4'b0011);
    stallF = 1'b1;
    tick();
    chk("ghr_after3", ghrD, 4'b0111);
    stallF = 1'b0; branchF = 1'b0;
    tick();
    chk("stallF_no_shift", ghrD, 4'b0111);
    branchF = 1'b1; stallD = 1'b1;
    tick();
    chk("stallD_hold", ghrD, 4'b0111);
    branchF = 1'b0; stallD = 1'b0;
    tick();
    chk("shift_under_stallD", ghrD, 4'b1111);

    // Set GHR=1011 through a repair, then repair again alongside an F shift.
    branchM = 1'b1; pcM = '0; ghrM = 4'b0101; pred_takeM = 1'b0; actual_takeM = 1'b1;
    tick();
    m_idle();
    tick();
    chk("repair_to_1011", ghrD, 4'b1011);
    branchM = 1'b1; pcM = '0; ghrM = 4'b0001; pred_takeM = 1'b1; actual_takeM = 1'b0;
    branchF = 1'b1; pcF = 32'h4;
    tick();
    m_idle(); branchF = 1'b0;
    chk("ckpt_before_repair", ghrD, 4'b1011);
    chk("repair_branch_cnt", branch_cnt, 8);
    chk("repair_mispred_cnt", mispred_cnt, 2);
    tick();
    chk("repair_wins", ghrD, 4'b0010);

    // Gshare: GHR=0011, pc 0x14 -> idx6, pc 0x18 -> idx5.
    branchM = 1'b1; pcM = '0; ghrM = 4'b0001; pred_takeM = 1'b0; actual_takeM = 1'b1;
    tick();
    m_idle();
    pcF = 32'h14;
    tick();
    chk("gshare_ghr", ghrD, 4'b0011);
    chk("gshare_idx6_pre", pred_takeD, 1);
    pcF = 32'h18;
    tick();
    chk("gshare_idx5_pre", pred_takeD, 1);
    branchM = 1'b1; pcM = 32'h14; ghrM = 4'b0011;
    tick(); tick();
    m_idle();
    pcF = 32'h14;
    tick();
    chk("gshare_idx6_trained", pred_takeD, 0);
    pcF = 32'h18;
    tick();
    chk("gshare_idx5_kept", pred_takeD, 1);
    chk("gshare_branch_cnt", branch_cnt, 11);

    // Statistics saturation at 4 bits.
    branchM = 1'b1; pcM = 32'h3c; ghrM = '0; pred_takeM = 1'b1; actual_takeM = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk("branch_cnt_sat", branch_cnt, 15);
    pred_takeM = 1'b0;
    for (int i = 0; i < 13; i++) tick();
    m_idle();
    chk("mispred_cnt_sat", mispred_cnt, 15);
    chk("branch_cnt_hold", branch_cnt, 15);

    // Reset mid-sweep restarts a full sweep.
    branchD = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_sweep_low", init_done, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_branch_cnt", branch_cnt, 0);
    chk("rst2_mispred_cnt", mispred_cnt, 0);
    chk("rst2_ghrD", ghrD, 0);
    for (int i = 0; i < 16; i++) begin
      chk("resweep_low", init_done, 0);
      tick();
    end
    chk("resweep_high", init_done, 1);
    branchD = 1'b1; pcF = 32'h18;
    tick();
    chk("resweep_idx6", pred_takeD, 1);
    branchM = 1'b1; pcM = 32'h3c; ghrM = '0;
    tick();
    m_idle();
    pcF = 32'h3c;
    tick();
    chk("resweep_idx15", pred_takeD, 0);
    chk("resweep_branch_cnt", branch_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/branch_predict_gshare_ckpt.md
Name: branch_predict_gshare_ckpt

Overview:
Parametrised global-history direction predictor for the 5-stage pipeline. It supports a pure-global index mode and a gshare (PC XOR GHR) index mode.
- The speculative GHR is updated at F with the prediction.
- Each branch carries a GHR checkpoint down the pipe; the GHR is restored exactly from that checkpoint on an M-stage mispredict.
- The PHT is initialised by a one-entry-per-cycle sweep after reset.
- Branch and mispredict counters are exposed for performance monitoring.

Parameters:
PC_W, 32, instruction address width
GHR_W, 8, global history length in bits; must satisfy 1 <= GHR_W <= PHT_IDX_W
PHT_IDX_W, 10, PHT index width; the PHT has 2^PHT_IDX_W 2-bit counters
MODE, 1, 0 = global index (GHR zero-extended), 1 = gshare index (pc[PHT_IDX_W+1:2] XOR zero-extended GHR)
CTR_INIT, 2'b10, counter value written during the init sweep
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
pcF  in  PC_W  fetch PC
branchF  in  1  fetch instruction is a conditional branch
stallF  in  1  fetch stalled; GHR is not shifted
flushD  in  1  clear the D-stage register
stallD  in  1  hold the D-stage register
pred_takeD  out  1  D-stage prediction, qualified by branchD
branchD  in  1  D instruction is a branch
ghrD  out  GHR_W  GHR checkpoint (value before this branch's shift), for the pipe to carry to M
branchM  in  1  M instruction is a resolved branch
pcM  in  PC_W  PC of the M branch
ghrM  in  GHR_W  checkpoint carried with the M branch
pred_takeM  in  1  prediction carried with the M branch
actual_takeM  in  1  resolved direction
init_done  out  1  high once the PHT sweep has completed
branch_cnt  out  CNT_W  resolved branches
mispred_cnt  out  CNT_W  mispredicted branches

Behaviour:
- Counter encoding: 00 SNT, 01 WNT, 10 WT, 11 ST. Prediction = ctr[1]. Update saturates: taken increments to a maximum of 11; not-taken decrements to a minimum of 00.
- FSM states:
  - INIT: ptr starts at 0. Each cycle write PHT[ptr] = CTR_INIT and increment ptr. After ptr = 2^PHT_IDX_W-1 is written, go to RUN. The sweep takes exactly 2^PHT_IDX_W cycles.
  - RUN: normal operation. init_done=1 only in RUN.
- rst (any state, including mid-sweep) → INIT with ptr=0. Also on reset: GHR=0, D register=0, counters=0, init_done=0.
- In INIT:
  - Fetch prediction is forced to 0.
  - GHR is held at 0.
  - M-stage updates, repairs and counters are ignored.
- Fetch (RUN): idxF = f(pcF, GHR) per MODE; predF = PHT[idxF][1]; the read is combinational.
  - If branchF & ~stallF: GHR <= {GHR[GHR_W-2:0], predF}.
  - For GHR_W=1 the shift reduces to GHR <= predF.
- D register: rst|flushD → pred=0, ghrD=0. Else if ~stallD → capture predF and the pre-shift GHR. Else hold.
- pred_takeD = branchD & D.pred. One cycle of latency from F.
- M-stage (RUN, branchM):
  - idxM = f(pcM, ghrM).
  - PHT[idxM] is updated with actual_takeM.
  - branch_cnt increments.
  - If pred_takeM != actual_takeM: mispred_cnt increments and GHR <= {ghrM[GHR_W-2:0], actual_takeM}.
- Simultaneous events:
  - Repair and an F shift in the same cycle: repair wins, because the F branch is younger and is flushed.
  - PHT read and write to the same index in the same cycle: the read returns the old value (no bypass).
- Statistics counters saturate at all-ones and do not wrap.
- Outputs depend only on registered state and the current F inputs. No X on any output after reset.

Test Plan:
1. Reset and init: assert rst 1 cycle, PHT_IDX_W=4. init_done=0 for exactly 16 cycles, then 1. branchF during init gives pred_takeD=0 and leaves GHR=0. After init, every index predicts taken (CTR_INIT=10).
2. Saturation: MODE=0, GHR_W=4, fixed ghrM=0. Resolve 3 not-taken at M → idx0 goes 10→01→00→00, and F with GHR=0 predicts 0. Then 3 taken → 01→10→11, prediction 1.
3. Speculative shift and checkpoint: 3 back-to-back branchF with all predictions taken → GHR=0111 and ghrD sequence 0000, 0001, 0011. With stallF=1 a branchF leaves GHR unchanged. With stallD=1, ghrD holds.
4. Mispredict repair: GHR=1011, M branch with ghrM=0001, pred_takeM=1, actual_takeM=0, and branchF=1 in the same cycle → next GHR=0010. mispred_cnt=1, branch_cnt=1.
5. Gshare aliasing: MODE=1, PHT_IDX_W=4, GHR=0011, pcF=0x14 → idx = 0101^0011 = 0110. Training idx 6 to not-taken changes the prediction for pcF=0x14 but not for pcF=0x18 (idx 0101).
6. Reset mid-sweep and counter saturation: rst at sweep cycle 7 → the sweep restarts from ptr 0 and takes a full 16 cycles. With CNT_W=4, 17 resolved branches leave branch_cnt=15.
